bsg_mem_1rw_sync_banked_rv: RTL and testbench

Banked, byte-masked, single-port synchronous SRAM wrapper with a ready/valid request interface and a yumi-style response interface. Consecutive addresses interleave across banks_p single-port banks. A small response buffer absorbs read data under consumer backpressure. An optional post-reset sweep zeroes every word. It serves as a drop-in tile-local memory wherever the core needs flow-controlled rather than fixed-latency SRAM access.

---
 rtl/bsg_mem_1rw_sync_banked_rv.sv | 231 +++++++++++++++++++++++
 tb/tb_bsg_mem_1rw_sync_banked_rv.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_banked_rv.sv
// bsg_mem_1rw_sync_banked_rv
//
// Banked, byte-masked, single-port synchronous SRAM with a ready/valid request
// side and a yumi-style response side. Consecutive word addresses interleave
// across banks_p banks. A small response buffer absorbs read data when the
// consumer stalls. Credits are counted so that a request is only accepted when
// its response is guaranteed a slot. An optional sweep after reset zeroes every
// word before the first request is accepted.
//
// Ports
//   clk_i       clock
//   reset_n_i   synchronous, active-low reset
//   v_i         request valid
//   ready_o     request ready; a request transfers on v_i & ready_o
//   w_i         1 = write, 0 = read
//   addr_i      word address (low bits select the bank)
//   data_i      write data
//   mask_i      byte write enables (ignored on reads)
//   v_o         read response valid
//   data_o      read response data (held while v_o & ~yumi_i)
//   yumi_i      consumer takes the response; only legal while v_o = 1
//   clearing_o  high while the zeroing sweep runs
module bsg_mem_1rw_sync_banked_rv #(
    parameter int width_p          = 64,
    parameter int els_p            = 1024,
    parameter int banks_p          = 2,
    parameter int buf_els_p        = 2,
    parameter bit clear_on_reset_p = 1'b1,
    localparam int addr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp   = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] mask_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     clearing_o
);

    localparam int bank_bits_lp  = $clog2(banks_p);   // 0 when banks_p == 1
    localparam int bank_width_lp = (banks_p > 1) ? bank_bits_lp : 1;
    localparam int rows_lp       = els_p / banks_p;
    localparam int row_width_lp  = (rows_lp > 1) ? $clog2(rows_lp) : 1;
    localparam int ptr_width_lp  = $clog2(buf_els_p);
    localparam int cnt_width_lp  = $clog2(buf_els_p + 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                  state_reg, state_next;
    logic [row_width_lp-1:0] clear_row_reg, clear_row_next;
    logic                    clearing;

    // ------------------------------------------------------------------
    // Clear / ready FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg     <= clear_on_reset_p ? ST_CLEAR : ST_READY;
            clear_row_reg <= '0;
        end else begin
            state_reg     <= state_next;
            clear_row_reg <= clear_row_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        clear_row_next = clear_row_reg;
        case (state_reg)
            ST_CLEAR: begin
                clear_row_next = clear_row_reg + 1'b1;
                if (clear_row_reg == row_width_lp'(rows_lp - 1)) begin
                    state_next     = ST_READY;
                    clear_row_next = '0;
                end
            end
            default: begin
                state_next = ST_READY;
            end
        endcase
    end

    assign clearing   = (state_reg == ST_CLEAR);
    assign clearing_o = clearing;

    // ------------------------------------------------------------------
    // Request decode and credit check
    // ------------------------------------------------------------------
    logic                     inflight_reg;
    logic [bank_width_lp-1:0] rd_bank_reg;
    logic [cnt_width_lp-1:0]  buf_count_reg, buf_count_next;
    logic [cnt_width_lp:0]    occupancy;
    logic                     accept, accept_read;
    logic [bank_width_lp-1:0] req_bank;
    logic [row_width_lp-1:0]  req_row;

    generate
        if (banks_p > 1) begin : g_bank_field
            assign req_bank = addr_i[bank_width_lp-1:0];
        end else begin : g_no_bank_field
            assign req_bank = 1'b0;
        end
    endgenerate

    assign req_row = row_width_lp'(addr_i >> bank_bits_lp);

    // Every buffered word and every read still inside a RAM holds a credit,
    // so an accepted read always finds a free buffer slot if it stalls.
    assign occupancy   = {1'b0, buf_count_reg} + (cnt_width_lp + 1)'(inflight_reg);
    assign ready_o     = reset_n_i & ~clearing
                         & (occupancy < (cnt_width_lp + 1)'(buf_els_p));
    assign accept      = v_i & ready_o;
    assign accept_read = accept & ~w_i;

    // ------------------------------------------------------------------
    // Banks: during the sweep every bank writes zero to the same row.
    // ------------------------------------------------------------------
    logic                     mem_we;
    logic [row_width_lp-1:0]  mem_row;
    logic [width_p-1:0]       mem_data;
    logic [mask_width_lp-1:0] mem_mask;
    logic [banks_p-1:0]       bank_en;
    logic [width_p-1:0]       bank_dout [banks_p];

    assign mem_we   = clearing | w_i;
    assign mem_row  = clearing ? clear_row_reg : req_row;
    assign mem_data = clearing ? '0 : data_i;
    assign mem_mask = clearing ? '1 : mask_i;

    genvar gi;
    generate
        for (gi = 0; gi < banks_p; gi++) begin : g_bank
            logic [width_p-1:0] mem [rows_lp];
            logic [width_p-1:0] dout_reg;

            assign bank_en[gi] = clearing ? reset_n_i
                                          : (accept & (req_bank == bank_width_lp'(gi)));

            always_ff @(posedge clk_i) begin
                if (bank_en[gi]) begin
                    if (mem_we) begin
                        for (int b = 0; b < mask_width_lp; b++) begin
                            if (mem_mask[b]) begin
                                mem[mem_row][b*8 +: 8] <= mem_data[b*8 +: 8];
                            end
                        end
                    end else begin
                        dout_reg <= mem[mem_row];
                    end
                end
            end

            assign bank_dout[gi] = dout_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            inflight_reg <= 1'b0;
            rd_bank_reg  <= '0;
        end else begin
            inflight_reg <= accept_read;
            if (accept_read) begin
                rd_bank_reg <= req_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response buffer. With the buffer empty the RAM output is bypassed to
    // data_o; anything not taken that cycle is queued so order is kept and
    // data_o stays stable.
    // ------------------------------------------------------------------
    logic [width_p-1:0]      buf_mem [buf_els_p];
    logic [ptr_width_lp-1:0] head_reg, head_next;
    logic [ptr_width_lp-1:0] tail_reg, tail_next;
    logic [width_p-1:0]      ram_dout;
    logic                    buf_empty, enq, deq;

    assign ram_dout  = bank_dout[rd_bank_reg];
    assign buf_empty = (buf_count_reg == '0);
    assign v_o       = buf_empty ? inflight_reg : 1'b1;
    assign data_o    = buf_empty ? ram_dout : buf_mem[head_reg];
    assign deq       = yumi_i & ~buf_empty;
    assign enq       = inflight_reg & ~(buf_empty & yumi_i);

    always_comb begin
        head_next      = head_reg;
        tail_next      = tail_reg;
        buf_count_next = buf_count_reg + cnt_width_lp'(enq) - cnt_width_lp'(deq);
        if (enq) begin
            tail_next = (tail_reg == ptr_width_lp'(buf_els_p - 1)) ? '0 : tail_reg + 1'b1;
        end
        if (deq) begin
            head_next = (head_reg == ptr_width_lp'(buf_els_p - 1)) ? '0 : head_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            buf_count_reg <= '0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            buf_count_reg <= buf_count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            buf_mem[tail_reg] <= ram_dout;
        end
    end

`ifndef SYNTHESIS
    // Consumer must only take a response that is actually offered.
    yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_banked_rv.sv
// Directed, scoreboard-based bench for bsg_mem_1rw_sync_banked_rv.
// Two instances (2 banks and 4 banks) receive the same stimulus; read
// responses from both are checked against a reference memory model.
module tb_bsg_mem_1rw_sync_banked_rv;
    localparam int W  = 64;
    localparam int AW = 10;
    localparam int MW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, v_in, w_in, yumi, yumi_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [MW-1:0] mask;
    logic          ready, v_out, clearing;
    logic [W-1:0]  rdata;
    logic          ready4, v_out4, clearing4;
    logic [W-1:0]  rdata4;

    // Consumer takes a response whenever one is offered and taking is enabled.
    assign yumi = yumi_en & v_out;

    bsg_mem_1rw_sync_banked_rv #(.width_p(W), .els_p(1024), .banks_p(2), .buf_els_p(2),
                                 .clear_on_reset_p(1'b1)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .ready_o(ready), .w_i(w_in),
        .addr_i(addr), .data_i(wdata), .mask_i(mask), .v_o(v_out), .data_o(rdata),
        .yumi_i(yumi), .clearing_o(clearing));

    bsg_mem_1rw_sync_banked_rv #(.width_p(W), .els_p(1024), .banks_p(4), .buf_els_p(2),
                                 .clear_on_reset_p(1'b1)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .ready_o(ready4), .w_i(w_in),
        .addr_i(addr), .data_i(wdata), .mask_i(mask), .v_o(v_out4), .data_o(rdata4),
        .yumi_i(yumi), .clearing_o(clearing4));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q [$];
    int           pop_cyc [$];
    logic [W-1:0] model [int];
    bit           acc_now;
    int           acc_cyc;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mread(input int a);
        return model.exists(a) ? model[a] : '0;
    endfunction

    // Called at the negative edge: tracks accepted requests into the model
    // and scoreboard, and checks any response taken this cycle.
    task automatic observe();
        logic [W-1:0] m;
        logic [W-1:0] e;
        acc_now = 1'b0;
        if (v_in && ready) begin
            acc_now = 1'b1;
            acc_cyc = cyc;
            if (w_in) begin
                m = mread(int'(addr));
                for (int b = 0; b < MW; b++) begin
                    if (mask[b]) m[b*8 +: 8] = wdata[b*8 +: 8];
                end
                model[int'(addr)] = m;
            end else begin
                exp_q.push_back(mread(int'(addr)));
            end
        end
        if (v_out && yumi) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", {63'b0, v_out}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rdata, e);
                check("rd_data_4bank", rdata4, e);
                pop_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [MW-1:0] m, output int ticks, output int acc_at);
        bit ok;
        ok = 1'b0;
        ticks = 0;
        v_in = 1'b1; w_in = we; addr = a; wdata = d; mask = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            observe();
            ok = acc_now;
            @(posedge clk);
            #1;
            ticks++;
            if (ok) break;
        end
        acc_at = acc_cyc;
        check(we ? "wr_accept" : "rd_accept", {63'b0, ok}, 64'd1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [MW-1:0] m);
        int t, c;
        issue(1'b1, a, d, m, t, c);
    endtask

    task automatic rd(input logic [AW-1:0] a, output int ticks, output int acc_at);
        issue(1'b0, a, '0, '0, ticks, acc_at);
    endtask

    task automatic idle();
        v_in = 1'b0;
        w_in = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Waits for both instances to finish their sweep; returns cycles each
    // spent clearing, count of ready-while-clearing and of stray valids.
    task automatic wait_clear(output int c2, output int c4, output int bad, output int stale);
        bit done;
        c2 = 0; c4 = 0; bad = 0; stale = 0; done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            observe();
            if (clearing) c2++;
            if (clearing4) c4++;
            if (clearing && ready) bad++;
            if (v_out || v_out4) stale++;
            done = !clearing && !clearing4;
            @(posedge clk);
            #1;
            if (done) break;
        end
        check("clear_finished", {63'b0, done}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c2, c4, bad, stale, t, a0, tot, n_acc;
        reset_n = 1'b0; v_in = 1'b1; w_in = 1'b0; addr = '0; wdata = '0; mask = '0;
        yumi_en = 1'b0;

        // Reset state (v_i held high during reset must be ignored).
        repeat (3) tick();
        @(negedge clk);
        check("reset_v_o", {63'b0, v_out}, 64'd0);
        check("reset_ready", {63'b0, ready}, 64'd0);
        check("reset_clearing", {63'b0, clearing}, 64'd1);
        @(posedge clk);
        #1;

        // Sweep length: 1024 words / 2 banks, and / 4 banks.
        idle();
        reset_n = 1'b1;
        wait_clear(c2, c4, bad, stale);
        check("clear_cycles_2bank", 64'(c2), 64'd512);
        check("clear_cycles_4bank", 64'(c4), 64'd256);
        check("ready_during_clear", 64'(bad), 64'd0);
        check("valid_during_clear", 64'(stale), 64'd0);
        @(negedge clk);
        check("ready_after_clear", {63'b0, ready}, 64'd1);
        @(posedge clk);
        #1;

        // Cleared contents.
        yumi_en = 1'b1;
        rd(10'd0, t, a0);
        rd(10'd1, t, a0);
        rd(10'd1023, t, a0);
        drain();

        // Masked writes, then read with one-cycle latency.
        wr(10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(10'd5, 64'h0000_0000_0000_1234, 8'h03);
        rd(10'd5, t, a0);
        idle();
        @(negedge clk);
        check("mask_rd_v_o_latency", {63'b0, v_out}, 64'd1);
        check("mask_rd_value", rdata, 64'hFFFF_FFFF_FFFF_1234);
        observe();
        @(posedge clk);
        #1;
        drain();

        // Streaming: 16 back-to-back reads, one response per cycle.
        for (int k = 0; k < 16; k++) wr(10'(k), 64'(k), 8'hFF);
        idle();
        tick();
        pop_cyc.delete();
        tot = 0;
        rd(10'd0, t, a0);
        tot += t;
        for (int k = 1; k < 16; k++) begin
            int c;
            rd(10'(k), t, c);
            tot += t;
        end
        drain();
        check("stream_issue_cycles", 64'(tot), 64'd16);
        check("stream_resp_count", 64'(pop_cyc.size()), 64'd16);
        if (pop_cyc.size() == 16) begin
            check("stream_first_resp_cycle", 64'(pop_cyc[0]), 64'(a0 + 1));
            check("stream_last_resp_cycle", 64'(pop_cyc[15]), 64'(a0 + 16));
        end

        // Backpressure: only two reads fit while nothing is consumed.
        yumi_en = 1'b0;
        n_acc = 0;
        v_in = 1'b1; w_in = 1'b0; addr = 10'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            observe();
            if (acc_now) n_acc++;
            if (v_out) check("bp_hold_data", rdata, 64'd8);
            @(posedge clk);
            #1;
            addr = 10'(8 + n_acc);
        end
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_ready_low", {63'b0, ready}, 64'd0);
        yumi_en = 1'b1;
        rd(10'd10, t, a0);
        rd(10'd11, t, a0);
        drain();

        // Bank interleave: distinct values, read back in reverse.
        for (int k = 0; k < 8; k++) wr(10'(k), 64'hC0DE_0000_0000_0000 | (64'(k) * 64'h0101_0101), 8'hFF);
        for (int k = 7; k >= 0; k--) rd(10'(k), t, a0);
        drain();

        // Mid-operation reset with two responses buffered.
        yumi_en = 1'b0;
        rd(10'd20, t, a0);
        rd(10'd21, t, a0);
        idle();
        tick();
        tick();
        @(negedge clk);
        check("buffered_before_reset", {63'b0, v_out}, 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        model.delete();
        @(negedge clk);
        check("midreset_v_o", {63'b0, v_out}, 64'd0);
        check("midreset_clearing", {63'b0, clearing}, 64'd1);
        @(posedge clk);
        #1;
        yumi_en = 1'b1;
        wait_clear(c2, c4, bad, stale);
        check("midreset_clear_cycles", 64'(c2), 64'd511);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            observe();
            if (v_out || v_out4) stale++;
            @(posedge clk);
            #1;
        end
        check("midreset_no_stale", 64'(stale), 64'd0);
        rd(10'd20, t, a0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
